// File: rtl/vlc_tx_scheduler_if.sv
// Word-source / serializer handshake bundle for vlc_tx_scheduler.
//   slave  : scheduler side (takes requests and serializer done, drives grants/word/load/status)
//   master : environment side (MAC word sources, serializer, error-clear control)
// Signals:
//   iReqA/iDataA/oGntA : payload source request, word, one-cycle grant
//   iReqB/iDataB/oGntB : control/beacon source request, word, one-cycle grant
//   iSerDone           : serializer finished shifting the current word
//   iErrClr            : clears the sticky timeout flag
//   oWord/oLoad        : word to serializer and its one-cycle capture strobe
//   oBusy/oSrc/oErr    : frame in progress, frame owner (0=A, 1=B), sticky timeout
interface vlc_tx_scheduler_if;
  logic        iReqA;
  logic [31:0] iDataA;
  logic        oGntA;
  logic        iReqB;
  logic [31:0] iDataB;
  logic        oGntB;
  logic        iSerDone;
  logic        iErrClr;
  logic [31:0] oWord;
  logic        oLoad;
  logic        oBusy;
  logic        oSrc;
  logic        oErr;

  modport slave (
    input  iReqA, iDataA, iReqB, iDataB, iSerDone, iErrClr,
    output oGntA, oGntB, oWord, oLoad, oBusy, oSrc, oErr
  );

  modport master (
    output iReqA, iDataA, iReqB, iDataB, iSerDone, iErrClr,
    input  oGntA, oGntB, oWord, oLoad, oBusy, oSrc, oErr
  );
endinterface

// File: rtl/vlc_tx_scheduler.sv
// Frame-level controller for the VLC transmit serializer.
// Arbitrates two word sources (A payload, B control/beacon), prefixes every frame with a
// preamble word, feeds words one at a time to a 32-bit serializer and waits for each to be
// shifted out, limits the burst length and inserts an idle gap after every frame.
// Ports:
//   iClk     : clock
//   iReset_n : asynchronous active-low reset
//   bus_io   : handshake bundle (see vlc_tx_scheduler_if), scheduler side
// Every output is a register; a state's actions become visible in the cycle after it.
module vlc_tx_scheduler #(
  parameter logic [31:0] PREAMBLE   = 32'hAAAA_AAAB,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  vlc_tx_scheduler_if.slave    bus_io
);

  localparam logic [3:0]  BurstLast   = 4'(MAX_BURST);
  localparam logic [7:0]  GapLast     = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreLoad,
    StPreWait,
    StDataGnt,
    StDataLoad,
    StDataWait,
    StGap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        load_q, load_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        busy_q, busy_d;
  logic        src_q, src_d;
  logic        err_q, err_d;
  logic        last_b_q, last_b_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [7:0]  gap_q, gap_d;

  logic        err_set;
  logic        ser_done;
  logic        owner_req;
  logic [31:0] owner_data;

  // load_q is high exactly in the first wait cycle; a done there belongs to the previous word.
  assign ser_done   = bus_io.iSerDone & ~load_q;
  assign owner_req  = src_q ? bus_io.iReqB  : bus_io.iReqA;
  assign owner_data = src_q ? bus_io.iDataB : bus_io.iDataA;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    load_d   = 1'b0;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    src_d    = src_q;
    last_b_d = last_b_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    gap_d    = gap_q;
    err_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.iReqA || bus_io.iReqB) begin
          // On a tie the source not served last wins.
          src_d   = bus_io.iReqB && (!bus_io.iReqA || !last_b_q);
          wcnt_d  = 4'd0;
          state_d = StPreLoad;
        end
      end
      StPreLoad: begin
        word_d  = PREAMBLE;
        load_d  = 1'b1;
        tcnt_d  = 16'd0;
        state_d = StPreWait;
      end
      StPreWait, StDataWait: begin
        if (tcnt_q != 16'hFFFF) begin
          tcnt_d = tcnt_q + 16'd1;
        end
        if (ser_done) begin
          if (state_q == StDataWait && wcnt_q == BurstLast) begin
            state_d = StGap;
          end else begin
            state_d = StDataGnt;
          end
        end else if (tcnt_q == TimeoutLast) begin
          err_set = 1'b1;
          state_d = StGap;
        end
      end
      StDataGnt: begin
        if (owner_req) begin
          gnt_a_d = ~src_q;
          gnt_b_d = src_q;
          word_d  = owner_data;
          wcnt_d  = wcnt_q + 4'd1;
          state_d = StDataLoad;
        end else begin
          state_d = StGap;
        end
      end
      StDataLoad: begin
        load_d  = 1'b1;
        tcnt_d  = 16'd0;
        state_d = StDataWait;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StGap && state_q != StGap) begin
      gap_d    = 8'd0;
      last_b_d = src_q;
    end

    // Set has priority over clear.
    err_d  = err_set | (err_q & ~bus_io.iErrClr);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= StIdle;
      word_q   <= 32'd0;
      load_q   <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      src_q    <= 1'b0;
      err_q    <= 1'b0;
      last_b_q <= 1'b1;
      wcnt_q   <= 4'd0;
      tcnt_q   <= 16'd0;
      gap_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      load_q   <= load_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      busy_q   <= busy_d;
      src_q    <= src_d;
      err_q    <= err_d;
      last_b_q <= last_b_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      gap_q    <= gap_d;
    end
  end

  assign bus_io.oWord = word_q;
  assign bus_io.oLoad = load_q;
  assign bus_io.oGntA = gnt_a_q;
  assign bus_io.oGntB = gnt_b_q;
  assign bus_io.oBusy = busy_q;
  assign bus_io.oSrc  = src_q;
  assign bus_io.oErr  = err_q;

endmodule

// File: tb/tb_vlc_tx_scheduler.sv
// Self-checking bench for vlc_tx_scheduler: word sources and a serializer are modelled
// cycle by cycle; the expected frame/word order comes from a frame-level reference model.
module tb_vlc_tx_scheduler;
  localparam logic [31:0] PREAMBLE   = 32'hAAAA_AAAB;
  localparam int          MAX_BURST  = 4;
  localparam int          GAP_CYCLES = 16;
  localparam int          TIMEOUT    = 1024;

  logic iClk = 1'b0;
  logic iReset_n = 1'b0;

  vlc_tx_scheduler_if bus ();

  vlc_tx_scheduler #(
    .PREAMBLE  (PREAMBLE),
    .MAX_BURST (MAX_BURST),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .iClk    (iClk),
    .iReset_n(iReset_n),
    .bus_io  (bus)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int last_done_cyc, load_cyc, ser_cnt, ser_lo, ser_hi;
  bit ser_en, src_en, stray_load, stray_gap, gnt_seen, busy_prev;
  logic [31:0] wa[$], wb[$], qa[$], qb[$];
  logic [32:0] exp_load[$], exp_gnt[$], obs_load[$], obs_gnt[$];
  int gap_q[$];

  // Frame-level reference: all words queued up front, arbitration after each frame.
  task automatic build_expected();
    int ia = 0;
    int ib = 0;
    bit last_b = 1'b1;
    bit own_b;
    logic [31:0] w;
    exp_load.delete();
    exp_gnt.delete();
    while (ia < wa.size() || ib < wb.size()) begin
      own_b = (ib < wb.size()) && (ia >= wa.size() || !last_b);
      exp_load.push_back({own_b, PREAMBLE});
      for (int k = 0; k < MAX_BURST; k++) begin
        if (own_b ? (ib >= wb.size()) : (ia >= wa.size())) break;
        if (own_b) begin w = wb[ib]; ib++; end
        else begin w = wa[ia]; ia++; end
        exp_load.push_back({own_b, w});
        exp_gnt.push_back({own_b, w});
      end
      last_b = own_b;
    end
  endtask

  // One clock: sample outputs after the edge, then drive sources and serializer.
  task automatic step();
    @(posedge iClk);
    #1;
    cyc++;
    bus.iSerDone = 1'b0;
    if (busy_prev && !bus.oBusy) gap_q.push_back(cyc - 1 - last_done_cyc);
    if (bus.oGntA && bus.oGntB) begin
      n_cmp++; n_bad++;
      $display("FAIL dual_gnt: both grants high at cycle %0d, required one", cyc);
    end
    if (bus.oGntA || bus.oGntB) begin
      n_cmp++;
      if (cyc !== last_done_cyc + 2) begin
        n_bad++;
        $display("FAIL gnt_timing: grant at cycle %0d, required %0d", cyc, last_done_cyc + 2);
      end
      obs_gnt.push_back({bus.oGntB, bus.oWord});
      if (bus.oGntB && qb.size() != 0) void'(qb.pop_front());
      if (bus.oGntA && qa.size() != 0) void'(qa.pop_front());
      gnt_seen = 1'b1;
    end
    if (bus.oLoad) begin
      obs_load.push_back({bus.oSrc, bus.oWord});
      n_cmp++;
      if (ser_cnt !== 0) begin
        n_bad++;
        $display("FAIL load_overlap: load with %0d cycles still shifting, required 0", ser_cnt);
      end
      load_cyc = cyc;
      if (ser_en) ser_cnt = int'($urandom_range(ser_hi, ser_lo));
      if (stray_load) bus.iSerDone = 1'b1;
    end else if (ser_cnt != 0) begin
      ser_cnt--;
      if (ser_cnt == 0) begin
        bus.iSerDone = 1'b1;
        last_done_cyc = cyc;
        gnt_seen = 1'b0;
      end
    end else if (stray_gap && !gnt_seen && cyc == last_done_cyc + 5) begin
      bus.iSerDone = 1'b1;
    end
    bus.iReqA  = src_en && qa.size() != 0;
    bus.iDataA = (qa.size() != 0) ? qa[0] : 32'd0;
    bus.iReqB  = src_en && qb.size() != 0;
    bus.iDataB = (qb.size() != 0) ? qb[0] : 32'd0;
    busy_prev  = bus.oBusy;
  endtask

  task automatic run_to_idle(input int budget, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(qa.size() == 0 && qb.size() == 0 && !bus.oBusy && ser_cnt == 0) && n < budget);
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic apply_reset();
    iReset_n = 1'b0;
    bus.iReqA = 1'b0; bus.iDataA = 32'd0; bus.iReqB = 1'b0; bus.iDataB = 32'd0;
    bus.iSerDone = 1'b0; bus.iErrClr = 1'b0;
    wa.delete(); wb.delete(); qa.delete(); qb.delete();
    obs_load.delete(); obs_gnt.delete(); gap_q.delete();
    ser_cnt = 0; ser_en = 1'b1; src_en = 1'b1; stray_load = 1'b0; stray_gap = 1'b0;
    gnt_seen = 1'b0; busy_prev = 1'b0; last_done_cyc = -1000; load_cyc = 0;
    ser_lo = 1; ser_hi = 4;
    repeat (2) @(posedge iClk);
    #2 iReset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if ({bus.oWord, bus.oLoad, bus.oGntA, bus.oGntB} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_word_strobes: got %h, required 0",
               {bus.oWord, bus.oLoad, bus.oGntA, bus.oGntB});
    end
    n_cmp++;
    if ({bus.oBusy, bus.oSrc, bus.oErr} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_status: got %b, required 000", {bus.oBusy, bus.oSrc, bus.oErr});
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    wa.push_back(32'h1234_5678);
    qa = wa;
    ser_lo = 40; ser_hi = 40;
    build_expected();
    run_to_idle(400, "single");
    n_cmp++;
    if (obs_load.size() !== exp_load.size()) begin
      n_bad++;
      $display("FAIL single_nload: got %0d, required %0d", obs_load.size(), exp_load.size());
    end
    for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
      n_cmp++;
      if (obs_load[i] !== exp_load[i]) begin
        n_bad++;
        $display("FAIL single_load[%0d]: got %h, required %h", i, obs_load[i], exp_load[i]);
      end
    end
    n_cmp++;
    if (obs_gnt.size() !== 1 || obs_gnt[0] !== {1'b0, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL single_gnt: got %0d grants, required one A grant of 12345678",
               obs_gnt.size());
    end
    // Frame ends in the grant state (no request), then the full gap.
    n_cmp++;
    if (gap_q.size() == 0 || gap_q[gap_q.size() - 1] !== GAP_CYCLES + 1) begin
      n_bad++;
      $display("FAIL single_gap: got %0d busy cycles after done, required %0d",
               (gap_q.size() != 0) ? gap_q[gap_q.size() - 1] : -1, GAP_CYCLES + 1);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    wa.push_back($urandom); wb.push_back($urandom);
    qa = wa; qb = wb;
    ser_lo = 3; ser_hi = 5;
    build_expected();
    run_to_idle(400, "tie");
    n_cmp++;
    if (obs_load.size() !== exp_load.size() || obs_gnt.size() !== exp_gnt.size()) begin
      n_bad++;
      $display("FAIL tie_count: got %0d loads %0d grants, required %0d loads %0d grants",
               obs_load.size(), obs_gnt.size(), exp_load.size(), exp_gnt.size());
    end
    for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
      n_cmp++;
      if (obs_load[i] !== exp_load[i]) begin
        n_bad++;
        $display("FAIL tie_load[%0d]: got %h, required %h", i, obs_load[i], exp_load[i]);
      end
    end
  endtask

  task automatic test_burst_limit();
    apply_reset();
    for (int i = 0; i < 6; i++) wa.push_back($urandom);
    qa = wa;
    ser_lo = 2; ser_hi = 5;
    build_expected();
    run_to_idle(600, "burst");
    n_cmp++;
    if (obs_load.size() !== exp_load.size() || obs_gnt.size() !== exp_gnt.size()) begin
      n_bad++;
      $display("FAIL burst_count: got %0d loads %0d grants, required %0d loads %0d grants",
               obs_load.size(), obs_gnt.size(), exp_load.size(), exp_gnt.size());
    end
    for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
      n_cmp++;
      if (obs_load[i] !== exp_load[i]) begin
        n_bad++;
        $display("FAIL burst_load[%0d]: got %h, required %h", i, obs_load[i], exp_load[i]);
      end
    end
    n_cmp++;
    if (gap_q.size() !== 2 || gap_q[0] !== GAP_CYCLES || gap_q[1] !== GAP_CYCLES + 1) begin
      n_bad++;
      $display("FAIL burst_gaps: got %0d frames first gap %0d, required 2 frames gaps %0d/%0d",
               gap_q.size(), (gap_q.size() != 0) ? gap_q[0] : -1, GAP_CYCLES, GAP_CYCLES + 1);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    wa.push_back($urandom);
    qa = wa;
    ser_en = 1'b0;
    bus.iErrClr = 1'b1;  // held through the timeout: set must beat clear
    while (!bus.oErr && n < TIMEOUT + 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (cyc - load_cyc !== TIMEOUT || bus.oErr !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_set: err=%b %0d cycles after load, required 1 after %0d",
               bus.oErr, cyc - load_cyc, TIMEOUT);
    end
    bus.iErrClr = 1'b0;
    src_en = 1'b0;
    qa.delete();
    bus.iReqA = 1'b0;
    run_to_idle(100, "timeout");
    n_cmp++;
    if (obs_gnt.size() !== 0 || obs_load.size() !== 1) begin
      n_bad++;
      $display("FAIL timeout_traffic: got %0d grants %0d loads, required 0 grants 1 load",
               obs_gnt.size(), obs_load.size());
    end
    n_cmp++;
    if (bus.oErr !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got %b, required 1", bus.oErr);
    end
    bus.iErrClr = 1'b1;
    step();
    bus.iErrClr = 1'b0;
    n_cmp++;
    if (bus.oErr !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got %b, required 0", bus.oErr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    apply_reset();
    wa.push_back($urandom); wa.push_back($urandom);
    qa = wa;
    ser_lo = 10; ser_hi = 10;
    while (obs_load.size() < 2 && n < 200) begin
      step();
      n++;
    end
    #2 iReset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.oWord, bus.oLoad, bus.oGntA, bus.oGntB, bus.oBusy, bus.oSrc, bus.oErr} !== 38'd0)
    begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h, required 0",
               {bus.oWord, bus.oLoad, bus.oGntA, bus.oGntB, bus.oBusy, bus.oSrc, bus.oErr});
    end
    wa.delete(); qa.delete(); obs_load.delete(); obs_gnt.delete(); gap_q.delete();
    ser_cnt = 0; busy_prev = 1'b0;
    bus.iReqA = 1'b0; bus.iSerDone = 1'b0;
    @(posedge iClk);
    #2 iReset_n = 1'b1;
    wb.push_back($urandom);
    qb = wb;
    ser_lo = 2; ser_hi = 4;
    build_expected();
    run_to_idle(400, "midreset");
    n_cmp++;
    if (obs_load.size() !== exp_load.size()) begin
      n_bad++;
      $display("FAIL midreset_nload: got %0d, required %0d", obs_load.size(), exp_load.size());
    end
    for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
      n_cmp++;
      if (obs_load[i] !== exp_load[i]) begin
        n_bad++;
        $display("FAIL midreset_load[%0d]: got %h, required %h", i, obs_load[i], exp_load[i]);
      end
    end
  endtask

  task automatic test_stray_done();
    apply_reset();
    bus.iSerDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.oBusy !== 1'b0 || bus.oLoad !== 1'b0) begin
        n_bad++;
        $display("FAIL stray_idle: busy=%b load=%b, required 0 0", bus.oBusy, bus.oLoad);
      end
    end
    wa.push_back($urandom);
    qa = wa;
    stray_load = 1'b1;
    stray_gap = 1'b1;
    ser_lo = 6; ser_hi = 9;
    build_expected();
    run_to_idle(400, "stray");
    for (int i = 0; i < exp_load.size(); i++) begin
      n_cmp++;
      if (i >= obs_load.size() || obs_load[i] !== exp_load[i]) begin
        n_bad++;
        $display("FAIL stray_load[%0d]: got %h, required %h", i,
                 (i < obs_load.size()) ? obs_load[i] : 33'h0, exp_load[i]);
      end
    end
    n_cmp++;
    if (gap_q.size() == 0 || gap_q[gap_q.size() - 1] !== GAP_CYCLES + 1) begin
      n_bad++;
      $display("FAIL stray_gap: got %0d busy cycles after done, required %0d",
               (gap_q.size() != 0) ? gap_q[gap_q.size() - 1] : -1, GAP_CYCLES + 1);
    end
  endtask

  task automatic test_random();
    int na, nb;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      na = int'($urandom_range(9, 0));
      nb = int'($urandom_range(9, 0));
      for (int i = 0; i < na; i++) wa.push_back($urandom);
      for (int i = 0; i < nb; i++) wb.push_back($urandom);
      qa = wa; qb = wb;
      ser_lo = 1; ser_hi = 6;
      build_expected();
      run_to_idle(3000, "random");
      n_cmp++;
      if (obs_load.size() !== exp_load.size() || obs_gnt.size() !== exp_gnt.size()) begin
        n_bad++;
        $display("FAIL rand%0d_count: got %0d loads %0d grants, required %0d loads %0d grants",
                 it, obs_load.size(), obs_gnt.size(), exp_load.size(), exp_gnt.size());
      end
      for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
        n_cmp++;
        if (obs_load[i] !== exp_load[i]) begin
          n_bad++;
          $display("FAIL rand%0d_load[%0d]: got %h, required %h", it, i, obs_load[i],
                   exp_load[i]);
        end
      end
      for (int i = 0; i < exp_gnt.size() && i < obs_gnt.size(); i++) begin
        n_cmp++;
        if (obs_gnt[i] !== exp_gnt[i]) begin
          n_bad++;
          $display("FAIL rand%0d_gnt[%0d]: got %h, required %h", it, i, obs_gnt[i],
                   exp_gnt[i]);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_word();
    test_tie();
    test_burst_limit();
    test_timeout();
    test_reset_mid_frame();
    test_stray_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
